// File: rtl/rx_fifo_pkg.sv
// Shared types and defaults for the UART receive byte FIFO.
// RX_FIFO_ERR_TAG_EN adds a per-entry error tag bit to rx_entry_t.
package rx_fifo_pkg;

    localparam int BYTE_W            = 8;
    localparam int DEFAULT_DEPTH     = 8;
    localparam int DEFAULT_ERR_CNT_W = 8;

    typedef struct packed {
`ifdef RX_FIFO_ERR_TAG_EN
        logic              err;
`endif
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/rx_fifo_mem.sv
// FIFO storage: DEPTH x rx_entry_t registers, one synchronous write port and
// one asynchronous read port. Storage is intentionally not reset.
module rx_fifo_mem
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  rx_entry_t       wdata,
    input  logic [AW-1:0]   raddr,
    output rx_entry_t       rdata
);

    rx_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/rx_byte_fifo.sv
// Receive byte buffer behind the UART receiver: edge-detected capture, error
// screening, show-ahead FIFO, sticky overflow and saturating bad-frame count.
// Optional feature macro: RX_FIFO_ERR_TAG_EN (store bad frames with a tag).
module rx_byte_fifo
    import rx_fifo_pkg::*;
#(
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BYTE_W-1:0]        P_DATA,
    input  logic                     data_valid,
    input  logic                     par_err,
    input  logic                     stop_err,
    input  logic                     rd_ready,
    input  logic                     ovf_clr,
    output logic [BYTE_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic                     rd_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [ERR_CNT_W-1:0]     err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef RX_FIFO_ERR_TAG_EN
    localparam logic TAG_MODE = 1'b1;
`else
    localparam logic TAG_MODE = 1'b0;
`endif

    logic          dv_q;
    logic          frame;
    logic          bad;
    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    rx_entry_t     wr_entry;
    rx_entry_t     rd_entry;

    assign frame    = data_valid & ~dv_q;
    assign bad      = par_err | stop_err;
    assign push_req = frame & (~bad | TAG_MODE);
    assign full     = (count == CW'(DEPTH));
    assign rd_valid = (count != '0);
    assign pop      = rd_valid & rd_ready;
    // A full FIFO still takes a byte when the head leaves in the same cycle.
    assign push     = push_req & (~full | pop);

    always_comb begin
        wr_entry      = '0;
        wr_entry.data = P_DATA;
`ifdef RX_FIFO_ERR_TAG_EN
        wr_entry.err  = bad;
`endif
    end

    rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    assign rd_data = rd_entry.data;
`ifdef RX_FIFO_ERR_TAG_EN
    // Gated so the tag reads 0 out of reset even though storage is not reset.
    assign rd_err = rd_valid & rd_entry.err;
`else
    assign rd_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dv_q     <= 1'b1;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            err_cnt  <= '0;
        end else begin
            dv_q <= data_valid;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
            if (frame && bad && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_CNT_W'(1);
            end
        end
    end

endmodule
